dcm_lock_monitor: RTL and testbench

- Consumer-side companion to the team's DCM clocking block.
- Runs on the DCM input clock and drives the DCM reset.
- Watches the DCM `locked` output and measures the frequency of one DCM-derived clock by counting its edges over a fixed window of sampling cycles.
- Declares the clock good only after several consecutive in-tolerance windows. On loss of lock or frequency error, it re-resets the DCM, up to a retry limit.

---
 rtl/dcm_lock_monitor.sv | 174 +++++++++++++++++
 tb/tb_dcm_lock_monitor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_monitor.sv
// dcm_lock_monitor: supervises a DCM from its input clock. Holds the DCM in
// reset, waits for lock, measures a derived clock over fixed windows and only
// reports freq_ok after GOOD_WINDOWS consecutive in-tolerance windows. Loss of
// lock or a bad window re-resets the DCM up to MAX_RETRY times, then FAIL.
// Optional build macro: LOCK_TIMEOUT_EN (bounds the wait for lock to TIMEOUT).
module dcm_lock_monitor #(
    parameter int WINDOW       = 1024,
    parameter int EXP_CNT      = 512,
    parameter int TOL          = 4,
    parameter int CNT_W        = 12,
    parameter int GOOD_WINDOWS = 4,
    parameter int RST_CYCLES   = 8,
    parameter int MAX_RETRY    = 3,
    parameter int TIMEOUT      = 4096
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             mon_clk,
    input  logic             dcm_locked,
    output logic             dcm_reset,
    output logic             freq_ok,
    output logic             fail,
    output logic             err_pulse,
    output logic [CNT_W-1:0] count_val,
    output logic [3:0]       retry_cnt
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int GC_W  = $clog2(GOOD_WINDOWS + 1);
    localparam logic [CNT_W:0] EXP_V = (CNT_W + 1)'(EXP_CNT);
    localparam logic [CNT_W:0] TOL_V = (CNT_W + 1)'(TOL);
    localparam logic [3:0] MAX_R = 4'((MAX_RETRY > 15) ? 15 : MAX_RETRY);

    // Catch nonsensical configurations at elaboration.
    if (WINDOW < 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("dcm_lock_monitor: WINDOW must be >= 16 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {S_RST, S_WAIT, S_MEAS, S_LOCK, S_FAIL} state_t;
    state_t state, state_nxt;

    logic [2:0]       mon_sync;
    logic [1:0]       lk_sync;
    logic             lk_s;
    logic             mon_edge;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_total;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   mag;
    logic [WIN_W-1:0] win_cnt;
    logic [RST_W-1:0] rst_cnt;
    logic [GC_W-1:0]  good_cnt;
    logic             measuring;
    logic             win_close;
    logic             win_good;
    logic             failure;
    logic             enter_meas;
`ifdef LOCK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]  to_cnt;
`endif

    assign lk_s      = lk_sync[1];
    assign mon_edge  = mon_sync[1] & ~mon_sync[2];
    assign measuring = (state == S_MEAS) || (state == S_LOCK);
    assign win_close = measuring && (win_cnt == WIN_W'(WINDOW - 1));

    // Window tally including this cycle's edge, and the tolerance judgement.
    always_comb begin
        edge_total = edge_cnt;
        if (mon_edge && (edge_cnt != '1))
            edge_total = edge_cnt + 1'b1;
        diff     = {1'b0, edge_total} - EXP_V;
        mag      = diff[CNT_W] ? (~diff + 1'b1) : diff;
        win_good = (mag <= TOL_V);
    end

    // Next-state logic; a lock loss coinciding with a bad window is one failure.
    always_comb begin
        state_nxt  = state;
        failure    = 1'b0;
        enter_meas = 1'b0;
        case (state)
            S_RST: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1))
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (lk_s) begin
                    state_nxt  = S_MEAS;
                    enter_meas = 1'b1;
                end
`ifdef LOCK_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT - 1))
                    failure = 1'b1;
`endif
            end
            S_MEAS: begin
                if (!lk_s)
                    failure = 1'b1;
                else if (win_close && win_good && (good_cnt == GC_W'(GOOD_WINDOWS - 1)))
                    state_nxt = S_LOCK;
            end
            S_LOCK: begin
                if (!lk_s || (win_close && !win_good))
                    failure = 1'b1;
            end
            S_FAIL: state_nxt = S_FAIL;
            default: state_nxt = S_RST;
        endcase
        if (failure)
            state_nxt = (retry_cnt < MAX_R) ? S_RST : S_FAIL;
    end

    // State register, synchronizers, counters and registered outputs.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= S_RST;
            mon_sync  <= '0;
            lk_sync   <= '0;
            edge_cnt  <= '0;
            win_cnt   <= '0;
            rst_cnt   <= '0;
            good_cnt  <= '0;
            dcm_reset <= 1'b1;
            freq_ok   <= 1'b0;
            fail      <= 1'b0;
            err_pulse <= 1'b0;
            count_val <= '0;
            retry_cnt <= '0;
`ifdef LOCK_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            mon_sync  <= {mon_sync[1:0], mon_clk};
            lk_sync   <= {lk_sync[0], dcm_locked};
            err_pulse <= failure;
            dcm_reset <= (state_nxt == S_RST);
            freq_ok   <= (state_nxt == S_LOCK);
            fail      <= (state_nxt == S_FAIL);
            if (failure && (retry_cnt < MAX_R))
                retry_cnt <= retry_cnt + 1'b1;
            if ((state == S_RST) && (state_nxt == S_RST))
                rst_cnt <= rst_cnt + 1'b1;
            else
                rst_cnt <= '0;
`ifdef LOCK_TIMEOUT_EN
            if ((state == S_WAIT) && (state_nxt == S_WAIT))
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
`endif
            if (enter_meas) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
                good_cnt <= '0;
            end else if (measuring) begin
                if (win_close) begin
                    win_cnt   <= '0;
                    edge_cnt  <= '0;
                    count_val <= edge_total;
                    if (state == S_MEAS)
                        good_cnt <= win_good ? good_cnt + 1'b1 : '0;
                end else begin
                    win_cnt  <= win_cnt + 1'b1;
                    edge_cnt <= edge_total;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcm_lock_monitor.sv
// Testbench for dcm_lock_monitor. mon_clk is synthesised so that each
// measurement window (aligned to the predicted start of measurement) carries
// an exact programmed number of edges; expected outputs follow from those
// counts and the lock/retry rules.
module tb_dcm_lock_monitor;

    localparam int W   = 256;
    localparam int EXP = 64;
    localparam int TOL = 4;

    logic        clkin      = 1'b0;
    logic        reset      = 1'b1;
    logic        mon_clk    = 1'b0;
    logic        dcm_locked = 1'b0;
    logic        dcm_reset, freq_ok, fail, err_pulse;
    logic [11:0] count_val;
    logic [3:0]  retry_cnt;

    int cyc    = 0;
    int rel    = 0;
    int anchor = 1 << 30;
    int nw [64];
    int tests  = 0;
    int fails  = 0;

    typedef struct {
        int n;      // edges programmed into the window
        int ok;     // freq_ok after the window closes
        int err;    // err_pulse after the window closes
        int retry;  // retry_cnt after the window closes
    } vec_t;
    vec_t tab [13];

    dcm_lock_monitor #(
        .WINDOW(W), .EXP_CNT(EXP), .TOL(TOL), .CNT_W(12), .GOOD_WINDOWS(4),
        .RST_CYCLES(8), .MAX_RETRY(3), .TIMEOUT(64)
    ) dut (
        .clkin(clkin), .reset(reset), .mon_clk(mon_clk), .dcm_locked(dcm_locked),
        .dcm_reset(dcm_reset), .freq_ok(freq_ok), .fail(fail), .err_pulse(err_pulse),
        .count_val(count_val), .retry_cnt(retry_cnt)
    );

    always #20 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    // mon_clk level sampled at posedge c+1; its edge is flagged at posedge c+3.
    // Window k of the current anchor owns flag posedges anchor+kW+1..anchor+(k+1)W.
    function automatic logic mon_at(input int c);
        int idx, off, n;
        idx = c + 2 - anchor;
        if (idx < 0) begin
            n   = EXP;
            off = ((idx % W) + W) % W;
        end else begin
            off = idx % W;
            n   = (idx / W < 64) ? nw[idx / W] : EXP;
        end
        return ((off + 1) * n / W) != (off * n / W);
    endfunction

    task automatic tick();
        @(negedge clkin);
        mon_clk = mon_at(cyc);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic fill_nw(input int v);
        for (int i = 0; i < 64; i++) nw[i] = v;
    endtask

    task automatic do_reset(input logic lk);
        reset      = 1'b1;
        dcm_locked = lk;
        anchor     = 1 << 30;
        repeat (5) tick();
        reset = 1'b0;
        rel   = cyc;
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1);
    end

    initial begin
        int c0, e, e5, n, wn, gc, m_retry, last_cnt, exp_err;
        bit m_lock, m_fail, good;

        tab[0]  = '{85, 0, 0, 1};
        tab[1]  = '{86, 0, 0, 1};
        tab[2]  = '{60, 0, 0, 1};
        tab[3]  = '{68, 0, 0, 1};
        tab[4]  = '{59, 0, 0, 1};
        tab[5]  = '{64, 0, 0, 1};
        tab[6]  = '{69, 0, 0, 1};
        tab[7]  = '{64, 0, 0, 1};
        tab[8]  = '{64, 0, 0, 1};
        tab[9]  = '{60, 0, 0, 1};
        tab[10] = '{68, 1, 0, 1};
        tab[11] = '{64, 1, 0, 1};
        tab[12] = '{85, 0, 1, 2};

        // Reset values and first lock with the nominal clock.
        fill_nw(EXP);
        do_reset(1'b0);
        chk("rst_dcm_reset", dcm_reset, 1);
        chk("rst_freq_ok", freq_ok, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_count", count_val, 0);
        chk("rst_retry", retry_cnt, 0);
        anchor = rel + 102;
        run_to(rel + 7);
        chk("dcm_reset_hold", dcm_reset, 1);
        run_to(rel + 8);
        chk("dcm_reset_release", dcm_reset, 0);
        run_to(rel + 99);
        dcm_locked = 1'b1;
        run_to(anchor + 4 * W - 1);
        chk("freq_ok_early", freq_ok, 0);
        run_to(anchor + 4 * W);
        chk("freq_ok_latency", freq_ok, 1);
        chk("lock_count", count_val, EXP);
        chk("lock_err", err_pulse, 0);

        // Lock dropped for 10 cycles mid-window while locked.
        c0 = cyc + 100;
        run_to(c0);
        dcm_locked = 1'b0;
        run_to(c0 + 2);
        chk("drop_ok_pending", freq_ok, 1);
        run_to(c0 + 3);
        e = cyc;
        chk("drop_freq_ok", freq_ok, 0);
        chk("drop_err", err_pulse, 1);
        chk("drop_retry", retry_cnt, 1);
        chk("drop_dcm_reset", dcm_reset, 1);
        run_to(e + 1);
        chk("drop_err_single", err_pulse, 0);
        for (int i = 0; i < 13; i++) nw[i] = tab[i].n;
        for (int i = 13; i < 64; i++) nw[i] = EXP;
        anchor = c0 + 13;
        run_to(e + 7);
        chk("retry_dcm_reset_hold", dcm_reset, 1);
        dcm_locked = 1'b1;
        run_to(e + 8);
        chk("retry_dcm_reset_release", dcm_reset, 0);

        // Window tolerance boundaries and good-run clearing.
        for (int i = 0; i < 13; i++) begin
            run_to(anchor + (i + 1) * W);
            chk($sformatf("tab%0d_count", i), count_val, tab[i].n);
            chk($sformatf("tab%0d_ok", i), freq_ok, tab[i].ok);
            chk($sformatf("tab%0d_err", i), err_pulse, tab[i].err);
            chk($sformatf("tab%0d_retry", i), retry_cnt, tab[i].retry);
        end

        // Lock loss on the same cycle as a bad window close: one failure.
        fill_nw(EXP);
        nw[4]  = 85;
        anchor = cyc + 9;
        e5     = anchor + 5 * W;
        run_to(e5 - 3);
        chk("coinc_locked", freq_ok, 1);
        dcm_locked = 1'b0;
        run_to(e5);
        chk("coinc_err", err_pulse, 1);
        chk("coinc_retry", retry_cnt, 3);
        chk("coinc_fail", fail, 0);
        chk("coinc_count", count_val, 85);
        run_to(e5 + 1);
        chk("coinc_err_single", err_pulse, 0);
        chk("coinc_retry_single", retry_cnt, 3);
        dcm_locked = 1'b1;
        fill_nw(EXP);
        anchor = e5 + 9;

        // Fourth failure exhausts retries; FAIL is sticky until reset.
        run_to(e5 + 30);
        dcm_locked = 1'b0;
        run_to(e5 + 33);
        chk("fail_err", err_pulse, 1);
        chk("fail_set", fail, 1);
        chk("fail_retry", retry_cnt, 3);
        chk("fail_dcm_reset", dcm_reset, 0);
        for (int i = 0; i < 6; i++) begin
            dcm_locked = i[0];
            repeat (100) tick();
            chk("fail_sticky", fail, 1);
            chk("fail_quiet_err", err_pulse, 0);
            chk("fail_no_dcm_reset", dcm_reset, 0);
            chk("fail_no_ok", freq_ok, 0);
        end
        do_reset(1'b1);
        chk("reset_clears_fail", fail, 0);
        chk("reset_clears_retry", retry_cnt, 0);
        chk("reset_dcm_reset", dcm_reset, 1);

        // Random window counts against a window-level reference model.
        anchor = rel + 9;
        for (int i = 0; i < 64; i++)
            nw[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(50, 90) : $urandom_range(59, 69);
        wn = 0; gc = 0; m_retry = 0; last_cnt = 0; m_lock = 0; m_fail = 0;
        for (int k = 0; k < 30; k++) begin
            if (m_fail) begin
                repeat (W) tick();
                chk("rnd_fail_sticky", fail, 1);
                chk("rnd_fail_count", count_val, last_cnt);
                chk("rnd_fail_ok", freq_ok, 0);
                chk("rnd_fail_dcm_reset", dcm_reset, 0);
            end else begin
                n = nw[wn];
                run_to(anchor + (wn + 1) * W);
                good     = (n >= EXP - TOL) && (n <= EXP + TOL);
                exp_err  = 0;
                last_cnt = n;
                if (!m_lock) begin
                    if (good) begin
                        gc++;
                        if (gc == 4) m_lock = 1;
                    end else begin
                        gc = 0;
                    end
                end else if (!good) begin
                    exp_err = 1;
                end
                if (exp_err != 0) begin
                    m_lock = 0;
                    gc     = 0;
                    if (m_retry < 3) begin
                        m_retry++;
                        anchor = cyc + 9;
                        wn     = 0;
                        for (int i = 0; i < 64; i++)
                            nw[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(50, 90) : $urandom_range(59, 69);
                    end else begin
                        m_fail = 1;
                    end
                end else begin
                    wn++;
                end
                chk("rnd_count", count_val, n);
                chk("rnd_ok", freq_ok, m_lock);
                chk("rnd_err", err_pulse, exp_err);
                chk("rnd_retry", retry_cnt, m_retry);
                chk("rnd_fail", fail, m_fail);
                if (exp_err != 0) chk("rnd_dcm_reset", dcm_reset, m_fail ? 0 : 1);
            end
        end

`ifdef LOCK_TIMEOUT_EN
        // Lock never arrives: a timeout failure every 8 + 64 cycles.
        do_reset(1'b0);
        for (int k = 1; k <= 4; k++) begin
            run_to(rel + 72 * k);
            chk($sformatf("timeout%0d_err", k), err_pulse, 1);
            chk($sformatf("timeout%0d_retry", k), retry_cnt, (k < 4) ? k : 3);
            chk($sformatf("timeout%0d_fail", k), fail, (k == 4) ? 1 : 0);
            chk($sformatf("timeout%0d_dcm_reset", k), dcm_reset, (k < 4) ? 1 : 0);
            run_to(rel + 72 * k + 1);
            chk($sformatf("timeout%0d_err_single", k), err_pulse, 0);
        end
`else
        // Lock never arrives: WAIT holds indefinitely without failing.
        do_reset(1'b0);
        run_to(rel + 400);
        chk("wait_no_err", err_pulse, 0);
        chk("wait_no_retry", retry_cnt, 0);
        chk("wait_no_fail", fail, 0);
        chk("wait_dcm_reset", dcm_reset, 0);
        chk("wait_no_ok", freq_ok, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
